// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for imm_ext_pipe: upstream immediate request and downstream result.
// master drives the request side and consumes results; slave is the extension block.
interface imm_ext_pipe_if #(
  parameter int IMM_W = 9,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IMM_W-1:0] in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_neg;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Immediate extension stage (sext6 / sextN / zextN / shl) with a registered valid/ready output.
// Define IMM_EXT_PIPE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module imm_ext_pipe #(
  parameter int OUT_W   = 16,
  parameter int IMM_W   = 9,
  parameter int SHL_AMT = 7
) (
  input logic          clk,
  input logic          rst,
  imm_ext_pipe_if.slave bus
);

  function automatic logic [OUT_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                               input logic [1:0]       mode);
    logic [OUT_W-1:0] r;
    r = '0;
    case (mode)
      2'b00:   r = {{(OUT_W-6){imm[5]}}, imm[5:0]};
      2'b01:   r = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
      2'b10:   r = {{(OUT_W-IMM_W){1'b0}}, imm};
      default: r = {{(OUT_W-IMM_W){1'b0}}, imm} << SHL_AMT;
    endcase
    return r;
  endfunction

  logic [OUT_W-1:0] res;
  logic             xin;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_neg_q, out_neg_d;

  assign res = ext_imm(bus.in_imm, bus.in_mode);
  assign xin = bus.in_valid && bus.in_ready;

`ifdef IMM_EXT_PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;

  // Ready depends only on state; rst gating keeps it low through the reset cycles.
  assign bus.in_ready = !rst && !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_neg_d    = out_neg_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || bus.out_ready) begin
      // Output stage free: skid has priority (in_ready is low whenever it is full).
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_neg_d    = skid_data_q[OUT_W-1];
        skid_valid_d = 1'b0;
      end else if (xin) begin
        out_valid_d = 1'b1;
        out_data_d  = res;
        out_neg_d   = res[OUT_W-1];
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (xin) begin
      skid_valid_d = 1'b1;
      skid_data_d  = res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  logic xout;

  assign xout         = out_valid_q && bus.out_ready;
  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_neg_d   = out_neg_q;
    if (xin) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_neg_d   = res[OUT_W-1];
    end else if (xout) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_neg_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_neg_q   <= out_neg_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_neg   = out_neg_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed vectors, streaming, stalls, reset
// and randomized traffic against a queue-based reference model.
module tb_imm_ext_pipe;
`ifdef IMM_EXT_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  longint unsigned q[$];

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.IMM_W(9),  .OUT_W(16)) bus ();
  imm_ext_pipe_if #(.IMM_W(12), .OUT_W(32)) bus2 ();

  imm_ext_pipe #(.OUT_W(16), .IMM_W(9), .SHL_AMT(7)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  imm_ext_pipe #(.OUT_W(32), .IMM_W(12), .SHL_AMT(20)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Reference: extension rules evaluated as signed integer arithmetic, then wrapped to ow bits.
  function automatic longint unsigned ref_ext(int ow, int iw, int sh, longint imm, int mode);
    longint v;
    longint m;
    m = (longint'(1) << ow) - 1;
    case (mode)
      0: begin v = imm % 64; if (v >= 32) v = v - 64; end
      1: begin v = imm; if (v >= (longint'(1) << (iw - 1))) v = v - (longint'(1) << iw); end
      2: v = imm;
      default: v = imm * (longint'(1) << sh);
    endcase
    return longint'(v & m);
  endfunction

  task automatic cyc(input logic v, input logic [8:0] imm, input logic [1:0] md,
                     input logic ordy, output logic xi, output logic xo,
                     output logic ov, output logic [15:0] od, output logic on);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_imm    = imm;
    bus.in_mode   = md;
    bus.out_ready = ordy;
    #1;
    xi = v && bus.in_ready;
    xo = bus.out_valid && ordy;
    ov = bus.out_valid;
    od = bus.out_data;
    on = bus.out_neg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 16'h0000) begin fails++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
    tests++; if (bus.out_neg !== 1'b0) begin fails++; $display("FAIL reset_out_neg got %b want 0", bus.out_neg); end
    tests++; if (bus2.out_valid !== 1'b0) begin fails++; $display("FAIL reset_wide_valid got %b want 0", bus2.out_valid); end
    rst = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [1:0]  md [5]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [8:0]  im [5]  = '{9'h03F, 9'h100, 9'h100, 9'h1FF, 9'h1C5};
    logic [15:0] ex [5]  = '{16'hFFFF, 16'hFF00, 16'h0100, 16'hFF80, 16'h0005};
    logic        ng [5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic xi, xo, ov, on;
    logic [15:0] od;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, im[i], md[i], 1'b1, xi, xo, ov, od, on);
      tests++; if (xi !== 1'b1) begin fails++; $display("FAIL dir_accept[%0d] got %b want 1", i, xi); end
      cyc(1'b0, 9'h0AA, 2'b11, 1'b1, xi, xo, ov, od, on);
      tests++; if (ov !== 1'b1) begin fails++; $display("FAIL dir_valid[%0d] got %b want 1", i, ov); end
      tests++; if (od !== ex[i]) begin fails++; $display("FAIL dir_data[%0d] got %h want %h", i, od, ex[i]); end
      tests++; if (on !== ng[i]) begin fails++; $display("FAIL dir_neg[%0d] got %b want %b", i, on, ng[i]); end
    end
    cyc(1'b0, 9'h0, 2'b00, 1'b1, xi, xo, ov, od, on);
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL dir_idle_valid got %b want 0", ov); end
  endtask

  task automatic test_stream();
    logic xi, xo, ov, on;
    logic [15:0] od;
    logic [8:0] im;
    logic [1:0] md;
    longint unsigned e;
    q.delete();
    for (int i = 0; i < 10; i++) begin
      im = 9'($urandom);
      md = 2'($urandom);
      cyc(i < 8, im, md, 1'b1, xi, xo, ov, od, on);
      if (i < 8) begin
        tests++; if (xi !== 1'b1) begin fails++; $display("FAIL stream_accept[%0d] got %b want 1", i, xi); end
      end
      if (i >= 1 && i <= 8) begin
        e = q.pop_front();
        tests++; if (ov !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b want 1", i, ov); end
        tests++; if (od !== 16'(e)) begin fails++; $display("FAIL stream_data[%0d] got %h want %h", i, od, 16'(e)); end
      end
      if (i == 9) begin
        tests++; if (ov !== 1'b0) begin fails++; $display("FAIL stream_tail_valid got %b want 0", ov); end
      end
      if (xi) q.push_back(ref_ext(16, 9, 7, longint'(im), int'(md)));
    end
  endtask

  task automatic test_stall();
    logic xi, xo, ov, on;
    logic [15:0] od;
    logic [8:0] im;
    logic [1:0] md;
    longint unsigned e;
    int acc = 0;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      im = 9'($urandom);
      md = 2'($urandom);
      cyc(1'b1, im, md, 1'b0, xi, xo, ov, od, on);
      if (i > 0) begin
        tests++; if (od !== 16'(q[0])) begin fails++; $display("FAIL stall_frozen[%0d] got %h want %h", i, od, 16'(q[0])); end
      end
      if (xi) begin acc++; q.push_back(ref_ext(16, 9, 7, longint'(im), int'(md))); end
    end
    tests++; if (acc != CAP) begin fails++; $display("FAIL stall_accepted got %0d want %0d", acc, CAP); end
    for (int i = 0; i < CAP + 2; i++) begin
      cyc(1'b0, 9'h1FF, 2'b01, 1'b1, xi, xo, ov, od, on);
      if (xo) begin
        e = (q.size() > 0) ? q.pop_front() : 64'hDEAD;
        tests++; if (od !== 16'(e)) begin fails++; $display("FAIL stall_drain[%0d] got %h want %h", i, od, 16'(e)); end
      end
    end
    tests++; if (q.size() != 0) begin fails++; $display("FAIL stall_left got %0d want 0", q.size()); end
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL stall_end_valid got %b want 0", ov); end
  endtask

  task automatic test_reset_mid_stall();
    logic xi, xo, ov, on;
    logic [15:0] od;
    for (int i = 0; i < 3; i++) cyc(1'b1, 9'h1F0, 2'b01, 1'b0, xi, xo, ov, od, on);
    tests++; if (ov !== 1'b1) begin fails++; $display("FAIL rstall_held got %b want 1", ov); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstall_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 16'h0000) begin fails++; $display("FAIL rstall_data got %h want 0000", bus.out_data); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 9'h0, 2'b00, 1'b1, xi, xo, ov, od, on);
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL rstall_emerge[%0d] got %b want 0", i, ov); end
    end
    q.delete();
  endtask

  task automatic test_random();
    logic xi, xo, ov, on, pov, pordy, v, ordy;
    logic [15:0] od, pod;
    logic [8:0] im;
    logic [1:0] md;
    longint unsigned e;
    pov = 1'b0; pordy = 1'b1; pod = '0;
    q.delete();
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      im   = 9'($urandom);
      md   = 2'($urandom);
      cyc(v, im, md, ordy, xi, xo, ov, od, on);
      tests++; if (ov !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid[%0d] got %b want %b", i, ov, q.size() != 0); end
      if (pov && !pordy) begin
        tests++; if (od !== pod) begin fails++; $display("FAIL rnd_hold[%0d] got %h want %h", i, od, pod); end
      end
      if (xo && q.size() > 0) begin
        e = q.pop_front();
        tests++; if (od !== 16'(e)) begin fails++; $display("FAIL rnd_data[%0d] got %h want %h", i, od, 16'(e)); end
        tests++; if (on !== e[15]) begin fails++; $display("FAIL rnd_neg[%0d] got %b want %b", i, on, e[15]); end
      end
      if (xi) q.push_back(ref_ext(16, 9, 7, longint'(im), int'(md)));
      tests++; if (q.size() > CAP) begin fails++; $display("FAIL rnd_occupancy[%0d] got %0d want <=%0d", i, q.size(), CAP); end
      pov = ov; pordy = ordy; pod = od;
    end
  endtask

  task automatic test_wide();
    logic [1:0]  md [2] = '{2'b01, 2'b11};
    logic [31:0] ex [2] = '{32'hFFFFF800, 32'h80000000};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus2.in_valid = 1'b1; bus2.in_imm = 12'h800; bus2.in_mode = md[i]; bus2.out_ready = 1'b1;
      #1;
      tests++; if (bus2.in_ready !== 1'b1) begin fails++; $display("FAIL wide_ready[%0d] got %b want 1", i, bus2.in_ready); end
      @(negedge clk);
      bus2.in_valid = 1'b0;
      #1;
      tests++; if (bus2.out_data !== ex[i]) begin fails++; $display("FAIL wide_data[%0d] got %h want %h", i, bus2.out_data, ex[i]); end
      tests++; if (bus2.out_neg !== 1'b1) begin fails++; $display("FAIL wide_neg[%0d] got %b want 1", i, bus2.out_neg); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_imm = '0; bus2.in_mode = '0; bus2.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_stream();
    test_stall();
    test_reset_mid_stall();
    test_random();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter OUT_W, default 16, output datapath width; legal range 10..32.
REQ-002 Parameter IMM_W, default 9, raw immediate field width; legal range 7..(OUT_W-1).
REQ-003 Parameter SHL_AMT, default 7, left-shift amount for mode 2'b11; legal range 0..(OUT_W-IMM_W).
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  1  upstream immediate valid.
REQ-007 Port in_ready  output  1  block can accept an immediate this cycle.
REQ-008 Port in_imm  input  IMM_W  raw immediate field.
REQ-009 Port in_mode  input  2  extension mode: 00 sext6, 01 sextN, 10 zextN, 11 shl.
REQ-010 Port out_valid  output  1  out_data holds a valid result.
REQ-011 Port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 Port out_data  output  OUT_W  extended immediate.
REQ-013 Port out_neg  output  1  result MSB, registered alongside out_data.

Function
REQ-014 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-015 Mode 00: out = in_imm[5:0] sign-extended from bit 5 to OUT_W; bits above 5 ignored.
REQ-016 Mode 01: out = in_imm sign-extended from bit IMM_W-1 to OUT_W.
REQ-017 Mode 10: out = in_imm zero-extended to OUT_W.
REQ-018 Mode 11: out = {zero-extended in_imm} << SHL_AMT, truncated to OUT_W, vacated LSBs zero.
REQ-019 Latency: result appears on out_data exactly one cycle after the accepting edge when the output stage is empty or draining.
REQ-020 Output register loads on transfer in; out_valid sets on transfer in, clears on transfer out with no simultaneous transfer in.
REQ-021 Simultaneous transfer in and transfer out in one cycle: out_valid stays 1, out_data takes the new result, no bubble.
REQ-022 Stall: while out_valid && !out_ready, out_data and out_neg hold stable.
REQ-023 Order preserved; no result dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 in_mode and in_imm sampled only on transfer in; changes at other times have no effect.

Reset
REQ-025 While rst high at a clock edge: out_valid=0, out_data=0, out_neg=0, any skid entry invalidated.
REQ-026 in_ready = 0 in every cycle in which rst is high; in_ready = 1 in the first cycle after rst deasserts.
REQ-027 Reset asserted mid-stall discards held and skid results; no transfer out after reset until a new transfer in.

Configuration
REQ-028 Macro IMM_EXT_PIPE_SKID_EN defined: one-entry skid buffer added; in_ready is a register output equal to "skid empty"; an accepted input arriving while the output stage stalls is captured in skid and moved to the output stage on the next transfer out; back-to-back throughput 1/cycle retained.
REQ-029 Macro IMM_EXT_PIPE_SKID_EN undefined: no skid storage; in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-030 Functional output sequence identical in both builds for identical accepted inputs.

Verification
REQ-031 Defaults, mode 00, in_imm=9'h03F -> out_data=16'hFFFF, out_neg=1, one cycle after accept.
REQ-032 Defaults, mode 01, in_imm=9'h100 -> 16'hFF00; mode 10, 9'h100 -> 16'h0100; mode 11, 9'h1FF -> 16'hFF80.
REQ-033 Stream 8 immediates with out_ready=1 every cycle -> 8 results on 8 consecutive cycles, in order, no bubbles.
REQ-034 out_ready=0 for 5 cycles with in_valid=1 -> out_data frozen; no build accepts more than 1 (skid undefined) or 2 (skid defined) items; release yields all in order.
REQ-035 rst pulsed during stall with out_valid=1 -> next cycle out_valid=0, out_data=16'h0000; held item never emerges.
REQ-036 OUT_W=32, IMM_W=12, SHL_AMT=20, mode 01, in_imm=12'h800 -> 32'hFFFFF800; mode 11 -> 32'h80000000.
